// File: rtl/shift_reg_universal.sv
// ---------------------------------------------------------------------------
// shift_reg_universal
//
// Universal WIDTH-bit shift register. Supports hold, shift left/right,
// rotate left/right, parallel load and synchronous clear. It counts the shifts
// made since the last load or clear, modulo WIDTH. It gives a one-cycle
// word_done pulse each time a full word of WIDTH shifts has been made.
// It can serve as a serializer (load, then shift out) or as a deserializer
// (shift in, then read q).
//
// Optional feature macro: SHIFT_ARITH_EN
//   defined   : mode 3'b111 is an arithmetic shift right (a shift op)
//   undefined : mode 3'b111 holds q and shift_cnt
//
// Parameters
//   WIDTH      register width, >= 2
//   RESET_VAL  value q takes on reset
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   en         operation enable; low holds q and shift_cnt
//   mode       operation select:
//                000 hold, 001 shl, 010 shr, 011 rol,
//                100 ror, 101 load, 110 clear, 111 asr/hold
//   sin_l      serial input, enters q[0] on shift left
//   sin_r      serial input, enters q[WIDTH-1] on shift right
//   load_data  parallel load value
//   q          register contents
//   sout_l     q[WIDTH-1], the bit leaving on a shift left
//   sout_r     q[0], the bit leaving on a shift right
//   shift_cnt  shifts since the last load/clear, modulo WIDTH
//   word_done  one-cycle pulse after the shift that wraps shift_cnt to 0
// ---------------------------------------------------------------------------
module shift_reg_universal #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ROL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;
  localparam logic [2:0] MODE_ASR   = 3'b111;

  // Terminal count. An explicit compare keeps the wrap correct for widths
  // that are not a power of two.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // Arithmetic shift right: the sign bit is replicated into the MSB.
  function automatic logic [WIDTH-1:0] asr1(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] s;
    s = $signed(v);
    return WIDTH'(s >>> 1);
  endfunction

  logic [WIDTH-1:0] q_next;
  logic             is_shift;
  logic             is_restart;
  logic             cnt_wrap;

  assign sout_l   = q[WIDTH-1];
  assign sout_r   = q[0];
  assign cnt_wrap = (shift_cnt == CNT_LAST);

  // Operation decode: next register value and the class of operation.
  always_comb begin
    q_next     = q;
    is_shift   = 1'b0;
    is_restart = 1'b0;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_SHL: begin
        q_next   = {q[WIDTH-2:0], sin_l};
        is_shift = 1'b1;
      end
      MODE_SHR: begin
        q_next   = {sin_r, q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_ROL: begin
        q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
        is_shift = 1'b1;
      end
      MODE_ROR: begin
        q_next   = {q[0], q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_LOAD: begin
        q_next     = load_data;
        is_restart = 1'b1;
      end
      MODE_CLEAR: begin
        // Clear goes to zero, not to RESET_VAL.
        q_next     = '0;
        is_restart = 1'b1;
      end
`ifdef SHIFT_ARITH_EN
      MODE_ASR: begin
        q_next   = asr1(q);
        is_shift = 1'b1;
      end
`else
      MODE_ASR: q_next = q;
`endif
      default: q_next = q;
    endcase
  end

  // Register stage: q, shift count and the word_done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q         <= RESET_VAL;
      shift_cnt <= '0;
      word_done <= 1'b0;
    end else begin
      // word_done is a pulse. It clears on every edge unless a wrap re-arms it.
      word_done <= 1'b0;
      if (en) begin
        q <= q_next;
        if (is_shift) begin
          shift_cnt <= cnt_wrap ? '0 : shift_cnt + 1'b1;
          word_done <= cnt_wrap;
        end else if (is_restart) begin
          shift_cnt <= '0;
        end
      end
    end
  end

`ifndef SHIFT_ARITH_EN
  // asr1 is used only when the arithmetic-shift feature is built in.
  logic unused_asr;
  assign unused_asr = ^asr1(q);
`endif

endmodule

// File: tb/tb_shift_reg_universal.sv
module tb_shift_reg_universal;
  localparam int         W  = 4;
  localparam logic [3:0] RV = 4'b1010;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic       sin_l;
  logic       sin_r;
  logic [3:0] load_data;
  logic [3:0] q;
  logic       sout_l;
  logic       sout_r;
  logic [1:0] shift_cnt;
  logic       word_done;

  shift_reg_universal #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_l(sin_l),
    .sin_r(sin_r), .load_data(load_data), .q(q), .sout_l(sout_l),
    .sout_r(sout_r), .shift_cnt(shift_cnt), .word_done(word_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model, kept as plain integers.
  int m_q, m_cnt, m_done;
  int cyc = 0;
  int pulse_cycles[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"},    32'(q),         32'(m_q));
    check({tag, ".cnt"},  32'(shift_cnt), 32'(m_cnt));
    check({tag, ".done"}, 32'(word_done), 32'(m_done));
    check({tag, ".soutl"}, 32'(sout_l),   32'((m_q / 8) % 2));
    check({tag, ".soutr"}, 32'(sout_r),   32'(m_q % 2));
  endtask

  task automatic model_reset();
    m_q = int'(RV); m_cnt = 0; m_done = 0;
  endtask

  // Apply one rising edge of the arithmetic model.
  task automatic model_edge();
    int  nq;
    bit  shift;
    nq = m_q; shift = 0; m_done = 0;
    if (en) begin
      case (int'(mode))
        1: begin nq = (m_q * 2 + int'(sin_l)) % 16;       shift = 1; end
        2: begin nq = m_q / 2 + 8 * int'(sin_r);          shift = 1; end
        3: begin nq = (m_q * 2) % 16 + m_q / 8;           shift = 1; end
        4: begin nq = m_q / 2 + 8 * (m_q % 2);            shift = 1; end
        5: begin nq = int'(load_data); m_cnt = 0; end
        6: begin nq = 0;               m_cnt = 0; end
`ifdef SHIFT_ARITH_EN
        7: begin nq = m_q / 2 + (m_q / 8) * 8;            shift = 1; end
`endif
        default: nq = m_q;
      endcase
      if (shift) begin
        if (m_cnt == W - 1) m_done = 1;
        m_cnt = (m_cnt + 1) % W;
      end
    end
    m_q = nq;
  endtask

  task automatic step(input string tag, input logic e, input logic [2:0] md,
                      input logic sl, input logic sr, input logic [3:0] ld);
    en = e; mode = md; sin_l = sl; sin_r = sr; load_data = ld;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    if (word_done === 1'b1) pulse_cycles.push_back(cyc);
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 0; mode = 0; sin_l = 0; sin_r = 0; load_data = 0;
    model_reset();
    #12;
    check_all("rst");
    reset = 1'b0;

    // Serialize: load, then four shl with a word_done pulse after the fourth.
    step("load1", 1, 3'b101, 0, 0, 4'b1001);
    step("shl_a", 1, 3'b001, 1, 0, 0);
    step("shl_b", 1, 3'b001, 0, 0, 0);
    step("shl_c", 1, 3'b001, 1, 0, 0);
    step("shl_d", 1, 3'b001, 1, 0, 0);
    check("wd_after4", 32'(word_done), 32'd1);
    // Async reset while word_done is high and the register is mid-use.
    pulse_reset("rst_mid");

    // Rotate a full word, then one ror.
    step("load2", 1, 3'b101, 0, 0, 4'b1000);
    for (int i = 0; i < 4; i++) step("rol", 1, 3'b011, 0, 0, 0);
    check("rol_back", 32'(q), 32'h8);
    step("ror", 1, 3'b100, 0, 0, 0);
    check("ror_q", 32'(q), 32'h4);
    check("ror_cnt", 32'(shift_cnt), 32'd1);

    // Shr with an enable gap; the count holds while en is low.
    step("clr0", 1, 3'b110, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("shr", 1, 3'b010, 0, 1, 0);
    step("gap0", 0, 3'b010, 0, 1, 0);
    step("gap1", 0, 3'b001, 0, 1, 0);
    check("gap_cnt", 32'(shift_cnt), 32'd3);
    step("shr4", 1, 3'b010, 0, 1, 0);
    check("shr4_done", 32'(word_done), 32'd1);
    step("shr5", 1, 3'b010, 0, 0, 0);
    step("clr_mid", 1, 3'b110, 0, 0, 0);

    // A load on the wrapping cycle wins, and no pulse follows.
    for (int i = 0; i < 3; i++) step("pre", 1, 3'b001, 1, 0, 0);
    step("load_wrap", 1, 3'b101, 0, 0, 4'h6);
    check("load_wrap_nodone", 32'(word_done), 32'd0);

    // Mode 111 on q=1000.
    step("load3", 1, 3'b101, 0, 0, 4'b1000);
    step("m111", 1, 3'b111, 0, 0, 0);
`ifdef SHIFT_ARITH_EN
    check("m111_q", 32'(q), 32'hC);
`else
    check("m111_q", 32'(q), 32'h8);
`endif

    // Continuous shl for 12 cycles: three pulses, four cycles apart.
    step("clr6", 1, 3'b110, 0, 0, 0);
    pulse_cycles.delete();
    for (int i = 0; i < 12; i++) step("cont", 1, 3'b001, 1'($urandom_range(0, 1)), 0, 0);
    check("pulse_count", 32'(pulse_cycles.size()), 32'd3);
    if (pulse_cycles.size() == 3) begin
      check("pulse_gap1", 32'(pulse_cycles[1] - pulse_cycles[0]), 32'd4);
      check("pulse_gap2", 32'(pulse_cycles[2] - pulse_cycles[1]), 32'd4);
    end

    // Randomized operation mix, with an occasional async reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) pulse_reset("rnd_rst");
      step("rnd", 1'($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
